apb_spi_slave: RTL and testbench

APB-programmable SPI slave (responder) that sits on the same APB bus as the SPI master peripheral and receives and transmits characters driven by an external SPI master. All SPI inputs are oversampled and synchronized into PCLK. Characters are 1–32 bits, with selectable mode (CPOL/CPHA) and bit order. Single-entry TX and RX holding registers are exposed to software, with full/overrun/underrun status and a level interrupt.

---
 rtl/apb_spi_slave_pkg.sv | 29 ++
 rtl/apb_spi_slave_sync.sv | 32 +++
 rtl/apb_spi_slave.sv | 180 ++++++++++++++++++
 tb/tb_apb_spi_slave.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_slave_pkg.sv
// Shared register offsets, CTRL/STAT bit positions and FSM encoding for the
// APB-programmable SPI slave.
package apb_spi_slave_pkg;

   localparam logic [4:0] SLV_RX   = 5'h00;
   localparam logic [4:0] SLV_TX   = 5'h04;
   localparam logic [4:0] SLV_CTRL = 5'h08;
   localparam logic [4:0] SLV_STAT = 5'h0C;

   localparam int CTRL_CPHA = 8;
   localparam int CTRL_CPOL = 9;
   localparam int CTRL_LSB  = 10;
   localparam int CTRL_IE   = 11;
   localparam int CTRL_EN   = 12;

   localparam int STAT_RXF  = 0;
   localparam int STAT_TXV  = 1;
   localparam int STAT_OVR  = 2;
   localparam int STAT_UNR  = 3;
   localparam int STAT_BUSY = 4;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} slv_state_t;

   // CHAR_LEN of 0 encodes a full 32-bit character.
   function automatic logic [5:0] char_bits(input logic [4:0] len);
      return (len == 5'd0) ? 6'd32 : {1'b0, len};
   endfunction

endpackage

// File: rtl/apb_spi_slave_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus rise/fall detect
// against a one-cycle-delayed copy of the synchronized level.
module spi_slave_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic PCLK,
   input  logic PRESETN,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1_q, s2_q, dly_q;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         s1_q  <= RST_VAL;
         s2_q  <= RST_VAL;
         dly_q <= RST_VAL;
      end else begin
         s1_q  <= d;
         s2_q  <= s1_q;
         dly_q <= s2_q;
      end
   end

   assign level = s2_q;
   assign rise  = s2_q & ~dly_q;
   assign fall  = ~s2_q & dly_q;

endmodule

// File: rtl/apb_spi_slave.sv
// APB-programmable SPI slave: register block, IDLE/LOAD/SHIFT FSM, bit counter
// and shift register, all in PCLK with oversampled SPI pins.
module apb_spi_slave
   import apb_spi_slave_pkg::*;
#(
   parameter int CHAR_MAX = 32
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic [4:0]  PADDR,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic        IRQ,
   input  logic        sclk_i,
   input  logic        ss_n_i,
   input  logic        mosi_i,
   output logic        miso_o,
   output logic        miso_oe_o
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   spi_slave_sync #(.RST_VAL(1'b0)) u_sclk (.PCLK(PCLK), .PRESETN(PRESETN), .d(sclk_i),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   spi_slave_sync #(.RST_VAL(1'b1)) u_ss (.PCLK(PCLK), .PRESETN(PRESETN), .d(ss_n_i),
      .level(ss_lvl), .rise(ss_rise), .fall(ss_fall));
   spi_slave_sync #(.RST_VAL(1'b0)) u_mosi (.PCLK(PCLK), .PRESETN(PRESETN), .d(mosi_i),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   logic unused_sig;
   assign unused_sig = ^{PADDR[1:0], sclk_lvl, mosi_rise, mosi_fall};

   logic [CHAR_MAX-1:0] tx_q, rx_q, sh_q, sh_nxt, load_val, len_mask;
   logic [4:0]          len_q, msb_idx;
   logic [5:0]          cnt_q, nbits;
   logic                cpha_q, cpol_q, lsb_q, ie_q, en_q;
   logic                rxf_q, txv_q, ovr_q, unr_q, irq_q, miso_q;
   logic                acc, wr_tx, wr_ctrl, wr_stat, rd_rx;
   logic                sample_edge, shift_edge, first_bit, cur_bit, done;
   logic                busy, load_act, shift_act;
   slv_state_t          state_q, state_d;

   assign acc     = PSEL & PENABLE;
   assign wr_tx   = acc & PWRITE & (PADDR[4:2] == SLV_TX[4:2]);
   assign wr_ctrl = acc & PWRITE & (PADDR[4:2] == SLV_CTRL[4:2]);
   assign wr_stat = acc & PWRITE & (PADDR[4:2] == SLV_STAT[4:2]);
   assign rd_rx   = acc & ~PWRITE & (PADDR[4:2] == SLV_RX[4:2]);

   // Sample on rising when CPOL==CPHA; the shift edge is always the other one.
   assign sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
   assign shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

   assign nbits    = char_bits(len_q);
   assign msb_idx  = len_q - 5'd1;
   assign len_mask = (len_q == 5'd0) ? '1 : ((CHAR_MAX'(1) << len_q) - CHAR_MAX'(1));
   assign load_val = txv_q ? tx_q : '0;

   always_comb begin
      first_bit = lsb_q ? load_val[0] : load_val[msb_idx];
      cur_bit   = lsb_q ? sh_q[0] : sh_q[msb_idx];
      if (lsb_q) begin
         sh_nxt          = sh_q >> 1;
         sh_nxt[msb_idx] = mosi_lvl;
      end else begin
         sh_nxt = {sh_q[CHAR_MAX-2:0], mosi_lvl};
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en_q || ss_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (ss_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (sample_edge && cnt_q == 6'd1) state_d = LOAD;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      load_act  = (state_q == LOAD);
      shift_act = (state_q == SHIFT) && en_q && !ss_rise;
      done      = shift_act && sample_edge && (cnt_q == 6'd1);
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         tx_q   <= '0;
         rx_q   <= '0;
         sh_q   <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
         cpha_q <= 1'b0;
         cpol_q <= 1'b0;
         lsb_q  <= 1'b0;
         ie_q   <= 1'b0;
         en_q   <= 1'b0;
         rxf_q  <= 1'b0;
         txv_q  <= 1'b0;
         ovr_q  <= 1'b0;
         unr_q  <= 1'b0;
         irq_q  <= 1'b0;
         miso_q <= 1'b0;
      end else begin
         if (wr_ctrl && !busy) begin
            len_q  <= PWDATA[4:0];
            cpha_q <= PWDATA[CTRL_CPHA];
            cpol_q <= PWDATA[CTRL_CPOL];
            lsb_q  <= PWDATA[CTRL_LSB];
            ie_q   <= PWDATA[CTRL_IE];
            en_q   <= PWDATA[CTRL_EN];
         end
         if (wr_stat) begin
            if (PWDATA[STAT_OVR]) ovr_q <= 1'b0;
            if (PWDATA[STAT_UNR]) unr_q <= 1'b0;
         end
         if (wr_tx) tx_q <= PWDATA[CHAR_MAX-1:0];
         // Set events are placed after the clears so they win on a collision.
         if (load_act) begin
            sh_q  <= load_val;
            cnt_q <= nbits;
            if (txv_q) txv_q <= 1'b0;
            else       unr_q <= 1'b1;
            if (!cpha_q) miso_q <= first_bit;
         end else if (shift_act) begin
            if (sample_edge) begin
               sh_q  <= sh_nxt;
               cnt_q <= cnt_q - 6'd1;
            end
            if (shift_edge) miso_q <= cur_bit;
         end
         if (wr_tx) txv_q <= 1'b1;
         if (done) begin
            if (!rxf_q || rd_rx) begin
               rx_q  <= sh_nxt & len_mask;
               rxf_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (rd_rx) begin
            rxf_q <= 1'b0;
         end
         irq_q <= ie_q & (rxf_q | ovr_q | unr_q);
      end
   end

   always_comb begin
      PRDATA  = '0;
      PSLVERR = 1'b0;
      case (PADDR[4:2])
         SLV_RX[4:2]:   PRDATA = 32'(rx_q);
         SLV_TX[4:2]:   PRDATA = 32'(tx_q);
         SLV_CTRL[4:2]: PRDATA = {19'd0, en_q, ie_q, lsb_q, cpol_q, cpha_q, 3'd0, len_q};
         SLV_STAT[4:2]: PRDATA = {27'd0, busy, unr_q, ovr_q, txv_q, rxf_q};
         default:       PSLVERR = acc;
      endcase
   end

   assign PREADY    = 1'b1;
   assign IRQ       = irq_q;
   assign miso_o    = miso_q;
   assign miso_oe_o = en_q & ~ss_lvl;

endmodule

// File: tb/tb_apb_spi_slave.sv
// Directed + randomized bench for apb_spi_slave: an SPI master model drives the
// pins, a character-level model predicts MISO data, RX and STAT.
module tb_apb_spi_slave;
   import apb_spi_slave_pkg::*;

   localparam int H = 8;

   logic        PCLK = 1'b0;
   logic        PRESETN = 1'b0;
   logic [4:0]  PADDR = '0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR, IRQ;
   logic        sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic        miso_o, miso_oe_o;

   apb_spi_slave #(.CHAR_MAX(32)) dut (
      .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .IRQ(IRQ), .sclk_i(sclk), .ss_n_i(ss_n), .mosi_i(mosi),
      .miso_o(miso_o), .miso_oe_o(miso_oe_o)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int failures = 0;

   // Character-level model state
   logic [31:0] m_tx, m_rx, m_exp, m_ctrl;
   logic        m_txv, m_rxf, m_ovr, m_unr, m_ie;
   int          c_len;
   logic        c_cpol, c_cpha, c_lsb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   function automatic logic [31:0] lmask(input int len);
      logic [31:0] one;
      one = 32'd1;
      return (len >= 32) ? 32'hFFFF_FFFF : ((one << len) - 32'd1);
   endfunction

   function automatic logic [31:0] exp_stat(input logic busy);
      return {27'd0, busy, m_unr, m_ovr, m_txv, m_rxf};
   endfunction

   task automatic model_reset();
      m_tx = '0; m_rx = '0; m_exp = '0; m_ctrl = '0;
      m_txv = 0; m_rxf = 0; m_ovr = 0; m_unr = 0; m_ie = 0;
   endtask

   // Every character starts by taking the pending TX value (or nothing).
   task automatic model_load();
      if (m_txv) begin
         m_exp = m_tx & lmask(c_len);
         m_txv = 0;
      end else begin
         m_exp = '0;
         m_unr = 1;
      end
   endtask

   task automatic model_done(input logic [31:0] w);
      if (!m_rxf) begin
         m_rx  = w & lmask(c_len);
         m_rxf = 1;
      end else begin
         m_ovr = 1;
      end
      model_load();
   endtask

   task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
      @(posedge PCLK); #1;
      PADDR = addr; PWDATA = data; PWRITE = 1; PSEL = 1; PENABLE = 0;
      @(posedge PCLK); #1;
      PENABLE = 1;
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic apb_read(input logic [4:0] addr, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      PADDR = addr; PWRITE = 0; PSEL = 1; PENABLE = 0;
      @(posedge PCLK); #1;
      PENABLE = 1;
      @(negedge PCLK);
      data = PRDATA;
      err  = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 0; PENABLE = 0;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(addr, d, e);
      check(tag, d, exp);
   endtask

   task automatic tx_write(input logic [31:0] v);
      apb_write(SLV_TX, v);
      m_tx = v; m_txv = 1;
   endtask

   task automatic w1c(input logic [31:0] v);
      apb_write(SLV_STAT, v);
      if (v[STAT_OVR]) m_ovr = 0;
      if (v[STAT_UNR]) m_unr = 0;
   endtask

   task automatic set_mode(input logic cpol, input logic cpha, input logic lsb,
                           input int len, input logic ie);
      logic [4:0] lf;
      lf = 5'(len);
      c_cpol = cpol; c_cpha = cpha; c_lsb = lsb; c_len = len; m_ie = ie;
      m_ctrl = {19'd0, 1'b1, ie, lsb, cpol, cpha, 3'd0, lf};
      apb_write(SLV_CTRL, m_ctrl);
      sclk = cpol;
      cyc(4);
   endtask

   task automatic ss_low();
      ss_n = 0;
      model_load();
      cyc(2 * H);
   endtask

   task automatic ss_high();
      ss_n = 1;
      cyc(2 * H);
   endtask

   // Clocks nb bits of one character; returns what the master saw on MISO
   // and what the model predicted for this character.
   task automatic spi_char(input logic [31:0] w, input int nb,
                           output logic [31:0] r, output logic [31:0] e);
      int bi;
      r = '0;
      e = m_exp;
      for (int i = 0; i < nb; i++) begin
         bi = c_lsb ? i : c_len - 1 - i;
         if (!c_cpha) begin
            mosi = w[bi];
            cyc(H);
            @(negedge PCLK);
            r[bi] = miso_o;
            @(posedge PCLK); #1;
            sclk = ~c_cpol;
            cyc(H);
            sclk = c_cpol;
         end else begin
            sclk = ~c_cpol;
            mosi = w[bi];
            cyc(H);
            @(negedge PCLK);
            r[bi] = miso_o;
            @(posedge PCLK); #1;
            sclk = c_cpol;
            cyc(H);
         end
      end
      if (nb == c_len) model_done(w);
   endtask

   initial begin
      logic [31:0] r, e, d, w;
      logic        err;
      int          len;

      model_reset();
      c_len = 8; c_cpol = 0; c_cpha = 0; c_lsb = 0;

      // Reset state
      cyc(3);
      check("rst_miso_oe", {31'd0, miso_oe_o}, 32'd0);
      check("rst_miso", {31'd0, miso_o}, 32'd0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      PRESETN = 1;
      cyc(2);
      rd_check("rst_stat", SLV_STAT, 32'd0);
      rd_check("rst_rx", SLV_RX, 32'd0);
      rd_check("rst_ctrl", SLV_CTRL, 32'd0);
      rd_check("rst_tx", SLV_TX, 32'd0);

      // Mode 0, 8 bits, MSB first, IE on
      set_mode(0, 0, 0, 8, 1);
      rd_check("ctrl_rb", SLV_CTRL, m_ctrl);
      tx_write(32'hA5);
      ss_low();
      check("m0_oe", {31'd0, miso_oe_o}, 32'd1);
      spi_char(32'h3C, 8, r, e);
      ss_high();
      check("m0_miso", r, e);
      check("m0_miso_a5", r, 32'hA5);
      rd_check("m0_stat", SLV_STAT, exp_stat(0));
      check("m0_irq_set", {31'd0, IRQ}, {31'd0, m_ie & (m_rxf | m_ovr | m_unr)});
      w1c(32'h8);
      cyc(2);
      check("m0_irq_rxf", {31'd0, IRQ}, {31'd0, m_ie & (m_rxf | m_ovr | m_unr)});
      rd_check("m0_rx", SLV_RX, m_rx);
      m_rxf = 0;
      rd_check("m0_stat_clr", SLV_STAT, exp_stat(0));
      cyc(2);
      check("m0_irq_clr", {31'd0, IRQ}, {31'd0, m_ie & (m_rxf | m_ovr | m_unr)});

      // Mode 3, LSB first, 32 bits
      set_mode(1, 1, 1, 32, 0);
      tx_write(32'h1234_5678);
      ss_low();
      spi_char(32'hDEAD_BEEF, 32, r, e);
      ss_high();
      check("m3_miso", r, 32'h1234_5678);
      rd_check("m3_rx", SLV_RX, 32'hDEAD_BEEF);
      m_rxf = 0;
      rd_check("m3_stat", SLV_STAT, exp_stat(0));

      // Back-to-back characters without reading RX
      set_mode(0, 0, 0, 8, 0);
      w1c(32'hC);
      tx_write(32'h5A);
      ss_low();
      spi_char(32'h11, 8, r, e);
      check("b2b_miso0", r, e);
      spi_char(32'h22, 8, r, e);
      check("b2b_miso1", r, e);
      ss_high();
      rd_check("b2b_stat", SLV_STAT, exp_stat(0));
      rd_check("b2b_rx", SLV_RX, 32'h11);
      m_rxf = 0;
      w1c(32'h4);
      rd_check("b2b_w1c", SLV_STAT, exp_stat(0));

      // Underrun: no TX written
      w1c(32'hC);
      ss_low();
      spi_char($urandom & 32'hFF, 8, r, e);
      ss_high();
      check("unr_miso", r, 32'd0);
      rd_check("unr_stat", SLV_STAT, exp_stat(0));
      d = m_rx;
      if (m_rxf) begin
         rd_check("unr_rx", SLV_RX, m_rx);
         m_rxf = 0;
      end

      // Abort after 5 of 8 bits
      ss_low();
      spi_char(32'hFF, 5, r, e);
      ss_high();
      rd_check("abort_stat", SLV_STAT, exp_stat(0));
      rd_check("abort_rx", SLV_RX, m_rx);
      ss_low();
      spi_char(32'h96, 8, r, e);
      ss_high();
      rd_check("abort_next_rx", SLV_RX, 32'h96);
      m_rxf = 0;

      // APB edge cases
      apb_read(5'h10, d, err);
      check("bad_err", {31'd0, err}, 32'd1);
      check("bad_data", d, 32'd0);
      ss_low();
      apb_write(SLV_CTRL, 32'h0000_1F05);
      rd_check("busy_stat", SLV_STAT, exp_stat(1));
      rd_check("busy_ctrl", SLV_CTRL, m_ctrl);
      ss_high();
      rd_check("idle_stat", SLV_STAT, exp_stat(0));

      // Reset mid-character
      tx_write(32'hC3);
      ss_low();
      spi_char(32'h0F, 3, r, e);
      PRESETN = 0;
      #1;
      check("prst_oe", {31'd0, miso_oe_o}, 32'd0);
      ss_n = 1; sclk = 0; mosi = 0;
      cyc(3);
      PRESETN = 1;
      model_reset();
      cyc(2);
      rd_check("prst_stat", SLV_STAT, 32'd0);
      rd_check("prst_ctrl", SLV_CTRL, 32'd0);
      check("prst_irq", {31'd0, IRQ}, 32'd0);

      // Randomized characters against the model
      for (int it = 0; it < 8; it++) begin
         len = $urandom_range(1, 32);
         set_mode($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  len, $urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) tx_write($urandom);
         w = $urandom;
         ss_low();
         spi_char(w, len, r, e);
         ss_high();
         check($sformatf("rnd%0d_miso", it), r, e);
         rd_check($sformatf("rnd%0d_stat", it), SLV_STAT, exp_stat(0));
         check($sformatf("rnd%0d_irq", it), {31'd0, IRQ}, {31'd0, m_ie & (m_rxf | m_ovr | m_unr)});
         if ($urandom_range(0, 3) != 0) begin
            rd_check($sformatf("rnd%0d_rx", it), SLV_RX, m_rx);
            m_rxf = 0;
         end
         w1c($urandom_range(0, 15));
         rd_check($sformatf("rnd%0d_stat2", it), SLV_STAT, exp_stat(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
